// File: rtl/fadd_norm_round.sv
// Float adder normalize/round stage: left-normalizes the difference
// one bit per cycle, rounds half-up on guard, packs IEEE-754 result.
//
// Ports:
//   clk, reset         clock, async active-high reset
//   in_valid/in_ready  operand handshake (ready only in IDLE)
//   mant_in            {hidden, fraction, guard} difference magnitude
//   round_in           bit below guard, enters on first shift
//   exp_in, sign_in    larger-operand exponent, result sign
//   out_valid/out_ready result handshake (valid only in DONE)
//   result             packed {sign, exp, frac}
//   zero_flag          exact zero
//   underflow_flag     flushed to zero
//   overflow_flag      saturated to infinity
module fadd_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FRAC_W+1:0]         mant_in,
  input  logic                      round_in,
  input  logic [EXP_W-1:0]          exp_in,
  input  logic                      sign_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      zero_flag,
  output logic                      underflow_flag,
  output logic                      overflow_flag
);

  localparam int MW = FRAC_W + 2;
  localparam int RW = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t              state, state_d;
  logic [MW-1:0]       mant, mant_d;
  logic                rnd, rnd_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                sign, sign_d;
  logic [RW-1:0]       res_d;
  logic                zf_d, uf_d, of_d;

  // Rounding datapath: one bit wider to expose the carry-out.
  logic [FRAC_W+1:0]   sum;
  logic                carry;
  logic [EXP_W-1:0]    exp_r;
  logic [FRAC_W-1:0]   frac_r;

  assign sum    = {1'b0, mant[MW-1:1]}
                + {{(FRAC_W+1){1'b0}}, mant[0]};
  assign carry  = sum[FRAC_W+1];
  assign exp_r  = exp_q + {{(EXP_W-1){1'b0}}, carry};
  assign frac_r = carry ? '0 : sum[FRAC_W-1:0];

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  always_comb begin
    state_d = state;
    mant_d  = mant;
    rnd_d   = rnd;
    exp_d   = exp_q;
    sign_d  = sign;
    res_d   = result;
    zf_d    = zero_flag;
    uf_d    = underflow_flag;
    of_d    = overflow_flag;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          mant_d = mant_in;
          rnd_d  = round_in;
          exp_d  = exp_in;
          sign_d = sign_in;
          zf_d   = 1'b0;
          uf_d   = 1'b0;
          of_d   = 1'b0;
          if (mant_in == '0 && !round_in) begin
            res_d   = '0;
            zf_d    = 1'b1;
            state_d = DONE;
          end else if (exp_in == '0) begin
            res_d   = {sign_in, {(RW-1){1'b0}}};
            uf_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mant[MW-1]) begin
          state_d = ROUND;
        end else if (exp_q == EXP_ONE) begin
          // No exponent left to absorb another shift.
          res_d   = {sign, {(RW-1){1'b0}}};
          uf_d    = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = {mant[MW-2:0], rnd};
          rnd_d  = 1'b0;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        exp_d = exp_r;
        if (exp_r == '1) begin
          res_d = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          of_d  = 1'b1;
        end else begin
          res_d = {sign, exp_r, frac_r};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mant           <= '0;
      rnd            <= 1'b0;
      exp_q          <= '0;
      sign           <= 1'b0;
      result         <= '0;
      zero_flag      <= 1'b0;
      underflow_flag <= 1'b0;
      overflow_flag  <= 1'b0;
    end else begin
      state          <= state_d;
      mant           <= mant_d;
      rnd            <= rnd_d;
      exp_q          <= exp_d;
      sign           <= sign_d;
      result         <= res_d;
      zero_flag      <= zf_d;
      underflow_flag <= uf_d;
      overflow_flag  <= of_d;
    end
  end

endmodule

// File: tb/tb_fadd_norm_round.sv
// Bench for fadd_norm_round: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_fadd_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mant_in;
  logic        round_in;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_flag;
  logic        underflow_flag;
  logic        overflow_flag;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  fadd_norm_round dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mant_in        (mant_in),
    .round_in       (round_in),
    .exp_in         (exp_in),
    .sign_in        (sign_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .zero_flag      (zero_flag),
    .underflow_flag (underflow_flag),
    .overflow_flag  (overflow_flag)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  // Reference: value v = {mant, round}; normalizing means moving
  // its leading one to the top, each move costing one exponent unit.
  task automatic model(input  logic [24:0] m,
                       input  logic        r,
                       input  logic [7:0]  e,
                       input  logic        s,
                       output logic [31:0] res,
                       output logic [2:0]  flg,
                       output int          lat);
    logic [25:0] v;
    int k, ex, sum;
    v = {m, r};
    res = 32'h0;
    flg = 3'b000;
    lat = 0;
    if (v == 0) begin
      flg = 3'b100;
    end else if (e == 0) begin
      res = {s, 31'h0};
      flg = 3'b010;
    end else begin
      k = 0;
      while (!v[25]) begin
        v = v << 1;
        k++;
      end
      if (k > int'(e) - 1) begin
        res = {s, 31'h0};
        flg = 3'b010;
        lat = int'(e);
      end else begin
        ex  = int'(e) - k;
        sum = int'(v[25:2]) + int'(v[1]);
        if (sum >= (1 << 24)) begin
          ex++;
          sum = 0;
        end
        if (ex == 255) begin
          res = {s, 8'hFF, 23'h0};
          flg = 3'b001;
        end else begin
          res = {s, 8'(ex), 23'(sum)};
        end
        lat = k + 2;
      end
    end
  endtask

  // Applies one operand, checks it, then completes the handshake
  // unless hold is set (caller then owns out_ready).
  task automatic op(input logic [24:0] m,
                    input logic        r,
                    input logic [7:0]  e,
                    input logic        s,
                    input bit          hold);
    logic [31:0] x_res;
    logic [2:0]  x_flg;
    int          x_lat, lat, w;
    model(m, r, e, s, x_res, x_flg, x_lat);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mant_in  = m;
    round_in = r;
    exp_in   = e;
    sign_in  = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(x_lat));
    chk("result", result, x_res);
    chk("flags",
        32'({zero_flag, underflow_flag, overflow_flag}),
        32'(x_flg));
    last_res = result;
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("res_held", result, x_res);
    end
  endtask

  initial begin
    logic [24:0] m;
    logic [7:0]  e;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    round_in  = 1'b0;
    exp_in    = '0;
    sign_in   = 1'b0;
    last_res  = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags",
        32'({zero_flag, underflow_flag, overflow_flag}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    op(25'h1000000, 1'b0, 8'd130, 1'b0, 1'b0);
    chk("plan_no_shift", last_res, 32'h41000000);
    op(25'h0400000, 1'b0, 8'd130, 1'b0, 1'b0);
    chk("plan_two_shift", last_res, 32'h40000000);
    op(25'h1FFFFFF, 1'b0, 8'd127, 1'b0, 1'b0);
    chk("plan_carry", last_res, 32'h40000000);
    op(25'h1FFFFFF, 1'b0, 8'd254, 1'b0, 1'b0);
    chk("plan_ovf", last_res, 32'h7F800000);
    op(25'h0000002, 1'b0, 8'd3, 1'b1, 1'b0);
    chk("plan_unf", last_res, 32'h80000000);
    op(25'h0000000, 1'b0, 8'd77, 1'b1, 1'b0);
    chk("plan_zero", last_res, 32'h00000000);
    op(25'h0000000, 1'b1, 8'd60, 1'b0, 1'b0);
    op(25'h0123456, 1'b1, 8'd0, 1'b1, 1'b0);
    op(25'h1800001, 1'b1, 8'd1, 1'b0, 1'b0);

    // Backpressure: result must hold, new operands ignored.
    op(25'h0400000, 1'b0, 8'd130, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      mant_in  = 25'h1FFFFFF;
      exp_in   = 8'd200;
      sign_in  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", result, 32'h40000000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release", 32'(in_ready), 32'd1);
    op(25'h1000000, 1'b0, 8'd131, 1'b1, 1'b0);
    chk("bp_next", last_res, 32'hC1800000);

    // Reset in the middle of normalization aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    mant_in  = 25'h0000100;
    round_in = 1'b0;
    exp_in   = 8'd130;
    sign_in  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    op(25'h0800000, 1'b1, 8'd100, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      m = 25'($urandom) >> $urandom_range(0, 26);
      if ($urandom_range(0, 15) == 0) m = 25'h1FFFFFF;
      if ($urandom_range(0, 3) == 0)
        e = 8'($urandom_range(0, 30));
      else
        e = 8'($urandom_range(1, 254));
      op(m, 1'($urandom), e, 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
